axil_rmw_engine: RTL and testbench

- Parametrised AXI4-Lite master that performs read-modify-write over a run of consecutive words in an AXI-Lite slave (e.g. axil_ram).
- Generalises the single stalled store: it handles a programmable base and count, has three arithmetic modes, and has a stall input.
- Responses that arrive during a stall are captured, never lost.
- Sits between the HLS-generated datapath control and a shared AXI-Lite memory.

---
 rtl/axil_rmw_engine.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_axil_rmw_engine.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_rmw_engine.sv
// axil_rmw_engine: AXI4-Lite master that read-modify-writes a run of consecutive words.
//
// A run is launched with a one-cycle start pulse that latches base_word, word_count,
// op and operand. Each word is read, modified (add / shift-left / xor / pass), and
// written back. Only one transaction is outstanding at any time.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   start           launch pulse, honoured only when not busy
//   base_word       word index of the first word (byte address = index << log2(STRB_WIDTH))
//   word_count      number of words in the run; 0 completes immediately
//   op, operand     modify mode (0 add, 1 shl by operand[4:0], 2 xor, 3 pass) and operand
//   stall           blocks request issue and state advance; response capture continues
//   busy, valid     run in progress / run complete (held until the next accepted start)
//   err             sticky error, set by any non-OKAY rresp or bresp during the run
//   s_axil_*        AXI4-Lite master-side read and write channels
//
// Build option: define AXIL_RMW_ERR_ABORT_EN to abort a run on the first non-OKAY
// response (the failing word is not written and the remaining words are skipped).

module axil_rmw_engine #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_word,
    input  logic [CNT_WIDTH-1:0]  word_count,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand,
    input  logic                  stall,
    output logic                  busy,
    output logic                  valid,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    output logic [2:0]            s_axil_awprot,
    output logic                  s_axil_awvalid,
    input  logic                  s_axil_awready,
    output logic [DATA_WIDTH-1:0] s_axil_wdata,
    output logic [STRB_WIDTH-1:0] s_axil_wstrb,
    output logic                  s_axil_wvalid,
    input  logic                  s_axil_wready,
    input  logic [1:0]            s_axil_bresp,
    input  logic                  s_axil_bvalid,
    output logic                  s_axil_bready,
    output logic [ADDR_WIDTH-1:0] s_axil_araddr,
    output logic [2:0]            s_axil_arprot,
    output logic                  s_axil_arvalid,
    input  logic                  s_axil_arready,
    input  logic [DATA_WIDTH-1:0] s_axil_rdata,
    input  logic [1:0]            s_axil_rresp,
    input  logic                  s_axil_rvalid,
    output logic                  s_axil_rready
);

`ifdef AXIL_RMW_ERR_ABORT_EN
    localparam bit AbortEn = 1'b1;
`else
    localparam bit AbortEn = 1'b0;
`endif

    localparam int unsigned ByteShift = $clog2(STRB_WIDTH);
    localparam int unsigned IdxWidth  = ADDR_WIDTH - ByteShift;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StRdReq   = 3'd1;
    localparam logic [2:0] StRdResp  = 3'd2;
    localparam logic [2:0] StModify  = 3'd3;
    localparam logic [2:0] StWrReq   = 3'd4;
    localparam logic [2:0] StWrResp  = 3'd5;
    localparam logic [2:0] StDone    = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [IdxWidth-1:0]   idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] operand_q, operand_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  cap_q, cap_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  arvalid_q, arvalid_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  err_q, err_d;

    logic                  ar_hs, aw_hs, w_hs;
    logic                  wr_issued;
    logic                  rsp_now;
    logic                  rsp_err_now;
    logic [ADDR_WIDTH-1:0] byte_addr;
    logic                  unused_base;

    // Index bits above the addressable word range are dropped, so the index wraps.
    assign unused_base = ^base_word;

    assign ar_hs     = arvalid_q & s_axil_arready;
    assign aw_hs     = awvalid_q & s_axil_awready;
    assign w_hs      = wvalid_q & s_axil_wready;
    assign wr_issued = awvalid_q | wvalid_q | aw_done_q | w_done_q;

    always_comb begin
        byte_addr = '0;
        byte_addr[ADDR_WIDTH-1:ByteShift] = idx_q;
    end

    // A response is usable either from the capture register or straight off the bus.
    always_comb begin
        rsp_now     = 1'b0;
        rsp_err_now = 1'b0;
        if (state_q == StRdResp) begin
            rsp_now     = cap_q | s_axil_rvalid;
            rsp_err_now = cap_q ? rsp_err_q : (s_axil_rresp != 2'b00);
        end else if (state_q == StWrResp) begin
            rsp_now     = cap_q | s_axil_bvalid;
            rsp_err_now = cap_q ? rsp_err_q : (s_axil_bresp != 2'b00);
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        operand_d = operand_q;
        hold_d    = hold_q;
        result_d  = result_q;
        cap_d     = cap_q;
        rsp_err_d = rsp_err_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    idx_d     = base_word[IdxWidth-1:0];
                    cnt_d     = word_count;
                    op_d      = op;
                    operand_d = operand;
                    err_d     = 1'b0;
                    cap_d     = 1'b0;
                    state_d   = (word_count == '0) ? StDone : StRdReq;
                end
            end

            StRdReq: begin
                if (!arvalid_q) begin
                    if (!stall) begin
                        arvalid_d = 1'b1;
                    end
                end else if (ar_hs) begin
                    // Move on regardless of stall so rready can catch the data.
                    arvalid_d = 1'b0;
                    cap_d     = 1'b0;
                    state_d   = StRdResp;
                end
            end

            StRdResp: begin
                if (!cap_q && s_axil_rvalid) begin
                    hold_d    = s_axil_rdata;
                    cap_d     = 1'b1;
                    rsp_err_d = (s_axil_rresp != 2'b00);
                    err_d     = err_q | (s_axil_rresp != 2'b00);
                end
                if (rsp_now && !stall) begin
                    cap_d   = 1'b0;
                    state_d = (AbortEn && rsp_err_now) ? StDone : StModify;
                end
            end

            StModify: begin
                if (!stall) begin
                    case (op_q)
                        2'd0:    result_d = hold_q + operand_q;
                        2'd1:    result_d = hold_q << operand_q[4:0];
                        2'd2:    result_d = hold_q ^ operand_q;
                        default: result_d = hold_q;
                    endcase
                    state_d = StWrReq;
                end
            end

            StWrReq: begin
                if (!wr_issued && !stall) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // AW and W may finish in either order or together.
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    cap_d     = 1'b0;
                    state_d   = StWrResp;
                end
            end

            StWrResp: begin
                if (!cap_q && s_axil_bvalid) begin
                    cap_d     = 1'b1;
                    rsp_err_d = (s_axil_bresp != 2'b00);
                    err_d     = err_q | (s_axil_bresp != 2'b00);
                end
                if (rsp_now && !stall) begin
                    cap_d = 1'b0;
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    idx_d = idx_q + IdxWidth'(1);
                    if ((AbortEn && rsp_err_now) || (cnt_q == CNT_WIDTH'(1))) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRdReq;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            operand_q <= '0;
            hold_q    <= '0;
            result_q  <= '0;
            cap_q     <= 1'b0;
            rsp_err_q <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            hold_q    <= hold_d;
            result_q  <= result_d;
            cap_q     <= cap_d;
            rsp_err_q <= rsp_err_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

    assign busy  = (state_q != StIdle) && (state_q != StDone);
    assign valid = (state_q == StDone);
    assign err   = err_q;

    assign s_axil_araddr  = byte_addr;
    assign s_axil_arprot  = 3'b000;
    assign s_axil_arvalid = arvalid_q;
    assign s_axil_rready  = (state_q == StRdResp);

    assign s_axil_awaddr  = byte_addr;
    assign s_axil_awprot  = 3'b000;
    assign s_axil_awvalid = awvalid_q;
    assign s_axil_wdata   = result_q;
    assign s_axil_wstrb   = '1;
    assign s_axil_wvalid  = wvalid_q;
    assign s_axil_bready  = (state_q == StWrResp);

endmodule

// File: tb/tb_axil_rmw_engine.sv
module tb_axil_rmw_engine;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int CW = 4;
`ifdef AXIL_RMW_ERR_ABORT_EN
    localparam bit Abort = 1'b1;
`else
    localparam bit Abort = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [AW-1:0] base_word = '0;
    logic [CW-1:0] word_count = '0;
    logic [1:0] op = '0;
    logic [DW-1:0] operand = '0;
    logic stall;
    logic busy, valid, err;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0] bresp, rresp;

    // Knobs, written only by the main process.
    bit ar_block = 0, rnd_ready = 0, wdelay = 0, stall_rnd = 0, stall_force = 0;
    int err_rd_word = -1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axil_rmw_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_word(base_word), .word_count(word_count),
        .op(op), .operand(operand), .stall(stall), .busy(busy), .valid(valid), .err(err),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_bresp(bresp),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_araddr(araddr),
        .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- slave stub ----------------
    logic [31:0] mem [32];
    logic ar_r = 1'b1, aw_r = 1'b1, w_r = 1'b1, stall_bit = 1'b0;
    logic aw_got, w_got;
    logic [4:0] aw_a;
    logic [31:0] w_d;
    int wcnt;
    int rd_total = 0, wr_total = 0;

    assign stall   = stall_force | stall_bit;
    assign arready = rnd_ready ? ar_r : !ar_block;
    assign awready = rnd_ready ? aw_r : 1'b1;
    assign wready  = wdelay ? (aw_got && wcnt == 0) : (rnd_ready ? w_r : 1'b1);

    always @(posedge clk) begin
        stall_bit <= stall_rnd && ($urandom_range(0, 3) == 0);
        ar_r <= ($urandom_range(0, 2) != 0);
        aw_r <= ($urandom_range(0, 2) != 0);
        w_r  <= ($urandom_range(0, 2) != 0);
        if (!rst) begin
            rvalid <= 1'b0; bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; wcnt <= 0;
            rdata <= '0; rresp <= '0; bresp <= '0; aw_a <= '0; w_d <= '0;
        end else begin
            if (rvalid && rready) rvalid <= 1'b0;
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= mem[araddr[6:2]];
                rresp  <= (int'(araddr[6:2]) == err_rd_word) ? 2'b10 : 2'b00;
                rd_total++;
            end
            if (wcnt > 0) wcnt <= wcnt - 1;
            if (awvalid && awready) begin
                aw_got <= 1'b1; aw_a <= awaddr[6:2]; wcnt <= 3;
            end
            if (wvalid && wready) begin
                w_got <= 1'b1; w_d <= wdata;
            end
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                mem[(awvalid && awready) ? awaddr[6:2] : aw_a] =
                    (wvalid && wready) ? wdata : w_d;
                wr_total++;
                aw_got <= 1'b0; w_got <= 1'b0;
                bvalid <= 1'b1; bresp <= 2'b00;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] expm [32];
    logic [6:0]  exp_ra[$];
    logic [6:0]  exp_wa[$];
    logic [31:0] exp_wd[$];
    bit exp_err;
    int exp_nrd, exp_nwr;

    task automatic model_run(input int base, input int cnt, input int mop, input logic [31:0] opnd);
        logic [31:0] h, r;
        int a;
        exp_err = 0; exp_nrd = 0; exp_nwr = 0;
        for (int i = 0; i < cnt; i++) begin
            a = (base + i) % 32;
            exp_ra.push_back(7'(a * 4)); exp_nrd++;
            h = expm[a];
            if (a == err_rd_word) begin
                exp_err = 1;
                if (Abort) break;
            end
            case (mop)
                0: r = h + opnd;
                1: r = h << opnd[4:0];
                2: r = h ^ opnd;
                default: r = h;
            endcase
            expm[a] = r;
            exp_wa.push_back(7'(a * 4)); exp_wd.push_back(r); exp_nwr++;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic p_rst = 1'b0, p_arv = 1'b0, p_arr = 1'b0, p_awv = 1'b0, p_awr = 1'b0;
    logic p_wv = 1'b0, p_wr = 1'b0;
    logic [6:0] p_ara, p_awa;
    logic [31:0] p_wd;
    bit r_in_stall = 0;

    always @(negedge clk) begin
        if (rst && p_rst) begin
            if (p_arv && !p_arr) chk("ar_hold", {araddr, arvalid}, {p_ara, 1'b1});
            if (p_awv && !p_awr) chk("aw_hold", {awaddr, awvalid}, {p_awa, 1'b1});
            if (p_wv && !p_wr)   chk("w_hold", wdata, p_wd);
            if (p_wv && !p_wr)   chk("w_valid_hold", wvalid, 1'b1);
            chk("busy_valid_excl", busy & valid, 1'b0);
            chk("single_outstanding", arvalid & (awvalid | wvalid), 1'b0);
            if (arvalid && arready) begin
                if (exp_ra.size() == 0) chk("extra_read", 1, 0);
                else chk("araddr", araddr, exp_ra.pop_front());
            end
            if (awvalid && awready) begin
                if (exp_wa.size() == 0) chk("extra_aw", 1, 0);
                else chk("awaddr", awaddr, exp_wa.pop_front());
            end
            if (wvalid && wready) begin
                if (exp_wd.size() == 0) chk("extra_w", 1, 0);
                else chk("wdata", wdata, exp_wd.pop_front());
            end
            if (rvalid && rready && stall) r_in_stall = 1;
        end
        p_rst = rst; p_arv = arvalid; p_arr = arready; p_ara = araddr;
        p_awv = awvalid; p_awr = awready; p_awa = awaddr;
        p_wv = wvalid; p_wr = wready; p_wd = wdata;
    end

    // ---------------- stimulus ----------------
    int rd0, wr0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int base, input int cnt, input int mop, input logic [31:0] opnd);
        model_run(base, cnt, mop, opnd);
        rd0 = rd_total; wr0 = wr_total;
        base_word = AW'(base); word_count = CW'(cnt); op = 2'(mop); operand = opnd;
        start = 1'b1;
        step();
        start = 1'b0;
        base_word = AW'($urandom); operand = $urandom;
    endtask

    task automatic finish_run(input int bound);
        int n;
        n = 0;
        while (!valid && n < bound) begin
            step();
            n++;
        end
        chk("valid_in_time", valid, 1'b1);
        chk("busy_done", busy, 1'b0);
        chk("err", err, exp_err);
        chk("reads_left", exp_ra.size(), 0);
        chk("writes_left", exp_wa.size() + exp_wd.size(), 0);
        chk("read_count", rd_total - rd0, exp_nrd);
        chk("write_count", wr_total - wr0, exp_nwr);
        for (int i = 0; i < 32; i++) chk($sformatf("mem[%0d]", i), mem[i], expm[i]);
    endtask

    task automatic load_mem(input bit rnd);
        for (int i = 0; i < 32; i++) begin
            mem[i] = rnd ? $urandom : 32'h0;
            expm[i] = mem[i];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_bready"}, bready, 0);
    endtask

    initial begin
        int n, b, c, o;
        load_mem(1'b0);
        rst = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b1;
        step();

        // Single add.
        mem[1] = 32'd10; expm[1] = 32'd10;
        launch(1, 1, 0, 32'd10);
        finish_run(10);
        chk("add_lit", mem[1], 32'd20);
        chk("add_err_lit", err, 1'b0);

        // Shift-left over four words.
        for (int i = 0; i < 4; i++) begin mem[i] = i + 1; expm[i] = i + 1; end
        launch(0, 4, 1, 32'd3);
        finish_run(60);
        for (int i = 0; i < 4; i++) chk("shl_lit", mem[i], 32'(8 * (i + 1)));

        // Same run with a stall right after arvalid rises.
        for (int i = 0; i < 4; i++) begin mem[i] = i + 1; expm[i] = i + 1; end
        r_in_stall = 0;
        launch(0, 4, 1, 32'd3);
        n = 0;
        while (!arvalid && n < 20) begin step(); n++; end
        chk("arvalid_rise", arvalid, 1'b1);
        stall_force = 1; ar_block = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("arvalid_in_stall", arvalid, 1'b1);
        end
        ar_block = 0;
        step(); step();
        stall_force = 0;
        chk("rdata_captured_in_stall", r_in_stall, 1'b1);
        finish_run(80);
        for (int i = 0; i < 4; i++) chk("stall_lit", mem[i], 32'(8 * (i + 1)));

        // Wrap from the last word to word 0.
        load_mem(1'b1);
        mem[31] = 32'h1234_5678; expm[31] = mem[31];
        mem[0] = 32'h0; expm[0] = 32'h0;
        launch(31, 2, 2, 32'hFFFF_0000);
        finish_run(40);
        chk("wrap_lit31", mem[31], 32'hEDCB_5678);
        chk("wrap_lit0", mem[0], 32'hFFFF_0000);

        // Delayed wready, then simultaneous readies.
        wdelay = 1;
        launch(4, 3, 0, 32'h1111);
        finish_run(80);
        wdelay = 0;
        launch(4, 3, 0, 32'h1111);
        finish_run(40);

        // Read error on the first word of a two-word run.
        err_rd_word = 5;
        launch(5, 2, 0, 32'd1);
        finish_run(40);
        chk("err_lit", err, 1'b1);
        chk("err_writes_lit", wr_total - wr0, Abort ? 0 : 2);
        err_rd_word = -1;

        // Zero-length run.
        launch(3, 0, 0, 32'd1);
        finish_run(3);

        // Reset in the middle of a run.
        launch(8, 8, 0, 32'd7);
        repeat (6) step();
        rst = 1'b0;
        step();
        check_reset_outputs("midreset");
        rst = 1'b1;
        exp_ra.delete(); exp_wa.delete(); exp_wd.delete();
        for (int i = 0; i < 32; i++) expm[i] = mem[i];
        step();

        // Randomized runs with random readies and stalls.
        rnd_ready = 1; stall_rnd = 1;
        for (int k = 0; k < 30; k++) begin
            b = $urandom_range(0, 31);
            c = $urandom_range(0, 15);
            o = $urandom_range(0, 3);
            err_rd_word = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : -1;
            launch(b, c, o, $urandom);
            finish_run(1500);
        end
        rnd_ready = 0; stall_rnd = 0; err_rd_word = -1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
